// File: rtl/trick_lock_pkg.sv
// Shared types and constants for the trick_lock_ctrl keypad lock.
// Digit 0 of any code lives in bits [3:0].
package trick_lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int PW_W       = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W      = 3;
  localparam int TIMER_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CHECK = 3'd2,
    ST_OPEN  = 3'd3,
    ST_SETPW = 3'd4,
    ST_ALARM = 3'd5
  } state_e;

  function automatic logic [PW_W-1:0] put_digit(
    input logic [PW_W-1:0]    pw,
    input logic [1:0]         pos,
    input logic [DIGIT_W-1:0] d
  );
    logic [PW_W-1:0] r;
    r = pw;
    r[{pos, 2'b00} +: DIGIT_W] = d;
    return r;
  endfunction

endpackage

// File: rtl/trick_lock_ctrl_if.sv
// Keypad strobes and lock status bundle.
// The keypad side is the master, the lock controller the slave.
interface trick_lock_ctrl_if;
  import trick_lock_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_value;
  logic               key_enter;
  logic               key_clear;
  logic               set_mode;
  logic [1:0]         digit_sel;
  logic [PW_W-1:0]    pw_entry;
  logic               unlock;
  logic               alarm;
  logic [1:0]         err_cnt;
  logic [2:0]         state;

  modport master (
    output key_valid, key_value, key_enter,
    output key_clear, set_mode,
    input  digit_sel, pw_entry, unlock,
    input  alarm, err_cnt, state
  );

  modport slave (
    input  key_valid, key_value, key_enter,
    input  key_clear, set_mode,
    output digit_sel, pw_entry, unlock,
    output alarm, err_cnt, state
  );

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and ALARM holds.
// Saturates at zero; done is high whenever the count is zero.
module lock_timer
  import trick_lock_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/trick_lock_ctrl.sv
// Keypad lock: 4-digit entry, check, timed open, password change
// and timed alarm after repeated failures.
module trick_lock_ctrl
  import trick_lock_pkg::*;
#(
  parameter logic [PW_W-1:0] DEF_PW    = 16'h1234,
  parameter int              MAX_ERR   = 3,
  parameter int              OPEN_CYC  = 32,
  parameter int              ALARM_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_value,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               set_mode,
  output logic [1:0]         digit_sel,
  output logic [PW_W-1:0]    pw_entry,
  output logic               unlock,
  output logic               alarm,
  output logic [1:0]         err_cnt,
  output logic [2:0]         state
);

  localparam logic [1:0]         MAX_E    = 2'(MAX_ERR);
  localparam logic [CNT_W-1:0]   FULL     = CNT_W'(NUM_DIGITS);
  localparam logic [TIMER_W-1:0] OPEN_LD  = TIMER_W'(OPEN_CYC - 1);
  localparam logic [TIMER_W-1:0] ALARM_LD = TIMER_W'(ALARM_CYC - 1);

  state_e             state_q, state_d;
  logic [PW_W-1:0]    entry_q, entry_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;
  logic               unlock_q, unlock_d;
  logic               alarm_q, alarm_d;

  logic               full;
  logic               match;
  logic [1:0]         err_inc;
  logic               do_clr;
  logic               do_ent;
  logic               do_dig;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;

  assign full    = (cnt_q == FULL);
  assign match   = full && (entry_q == pw_q);
  assign err_inc = err_q + 2'd1;

  // One-hot strobes: clear beats enter beats digit.
  assign do_clr = key_clear;
  assign do_ent = key_enter & ~key_clear;
  assign do_dig = key_valid & ~key_enter & ~key_clear
                & (key_value <= 4'd9) & ~full;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_ENTRY, ST_SETPW: begin
        unique case (1'b1)
          do_clr: begin
            entry_d = '0;
            cnt_d   = '0;
            if (state_q == ST_ENTRY) begin
              state_d = ST_IDLE;
            end
          end
          do_ent: begin
            if (state_q == ST_ENTRY) begin
              state_d = ST_CHECK;
            end else if (state_q == ST_SETPW) begin
              if (full) begin
                pw_d = entry_q;
              end
              entry_d = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
          do_dig: begin
            entry_d = put_digit(entry_q, cnt_q[1:0], key_value);
            cnt_d   = cnt_q + 1'b1;
            if (state_q == ST_IDLE) begin
              state_d = ST_ENTRY;
            end
          end
          default: ;
        endcase
      end
      ST_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (match) begin
          err_d   = '0;
          state_d = ST_OPEN;
        end else begin
          err_d   = err_inc;
          state_d = (err_inc >= MAX_E) ? ST_ALARM : ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (key_enter && set_mode) begin
          state_d = ST_SETPW;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (tmr_done) begin
          err_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they rise on entry.
  always_comb begin
    unlock_d = (state_d == ST_OPEN);
    alarm_d  = (state_d == ST_ALARM);
    tmr_load = (unlock_d && state_q != ST_OPEN)
             || (alarm_d && state_q != ST_ALARM);
    tmr_val  = alarm_d ? ALARM_LD : OPEN_LD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      entry_q  <= '0;
      pw_q     <= DEF_PW;
      cnt_q    <= '0;
      err_q    <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
    end
  end

  lock_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign digit_sel = full ? 2'd3 : cnt_q[1:0];
  assign pw_entry  = entry_q;
  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign err_cnt   = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_trick_lock_ctrl.sv
// Self-checking bench for trick_lock_ctrl: keypad model plus a
// scoreboard of expected check outcomes.
module tb_trick_lock_ctrl;
  import trick_lock_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trick_lock_ctrl_if bus ();

  trick_lock_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (bus.key_valid),
    .key_value (bus.key_value),
    .key_enter (bus.key_enter),
    .key_clear (bus.key_clear),
    .set_mode  (bus.set_mode),
    .digit_sel (bus.digit_sel),
    .pw_entry  (bus.pw_entry),
    .unlock    (bus.unlock),
    .alarm     (bus.alarm),
    .err_cnt   (bus.err_cnt),
    .state     (bus.state)
  );

  typedef struct {
    logic [2:0] st;
    logic [1:0] err;
    logic       unl;
    logic       alm;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [15:0] m_pw = 16'h1234;
  logic [15:0] m_entry = '0;
  int m_cnt = 0;
  int m_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    logic [1:0] es;
    bus.key_valid = 1'b1;
    bus.key_value = d;
    step();
    bus.key_valid = 1'b0;
    if (d <= 4'd9 && m_cnt < 4) begin
      m_entry[m_cnt*4 +: 4] = d;
      m_cnt++;
    end
    es = (m_cnt >= 4) ? 2'd3 : 2'(m_cnt);
    total++;
    if (bus.pw_entry !== m_entry) begin
      bad++;
      $display("FAIL digit_entry got=%h exp=%h", bus.pw_entry, m_entry);
    end
    total++;
    if (bus.digit_sel !== es) begin
      bad++;
      $display("FAIL digit_sel got=%0d exp=%0d", bus.digit_sel, es);
    end
  endtask

  // Keys in the digits of a code, digit 0 (bits [3:0]) first.
  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      press_digit(c[i*4 +: 4]);
    end
  endtask

  task automatic submit();
    exp_t e;
    if (m_cnt == 4 && m_entry == m_pw) begin
      m_err = 0;
      e = '{3'd3, 2'd0, 1'b1, 1'b0};
    end else begin
      m_err++;
      if (m_err >= 3) e = '{3'd5, 2'(m_err), 1'b0, 1'b1};
      else e = '{3'd0, 2'(m_err), 1'b0, 1'b0};
    end
    sb.push_back(e);
    m_entry = '0;
    m_cnt = 0;
    bus.key_enter = 1'b1;
    step();
    bus.key_enter = 1'b0;
    total++;
    if (bus.state !== 3'd2) begin
      bad++;
      $display("FAIL check_state got=%0d exp=2", bus.state);
    end
    step();
    e = sb.pop_front();
    total++;
    if (bus.state !== e.st) begin
      bad++;
      $display("FAIL result_state got=%0d exp=%0d", bus.state, e.st);
    end
    total++;
    if (bus.err_cnt !== e.err) begin
      bad++;
      $display("FAIL result_err got=%0d exp=%0d", bus.err_cnt, e.err);
    end
    total++;
    if (bus.unlock !== e.unl || bus.alarm !== e.alm) begin
      bad++;
      $display("FAIL result_flags got=%b%b exp=%b%b",
               bus.unlock, bus.alarm, e.unl, e.alm);
    end
    total++;
    if (bus.pw_entry !== 16'h0 || bus.digit_sel !== 2'd0) begin
      bad++;
      $display("FAIL result_entry got=%h/%0d exp=0/0",
               bus.pw_entry, bus.digit_sel);
    end
  endtask

  task automatic wait_open(input int exp_n);
    int n = 0;
    logic both = 1'b0;
    while (bus.unlock === 1'b1 && n < 200) begin
      if (bus.alarm === 1'b1) both = 1'b1;
      n++;
      step();
    end
    total++;
    if (n != exp_n) begin
      bad++;
      $display("FAIL open_len got=%0d exp=%0d", n, exp_n);
    end
    total++;
    if (bus.state !== 3'd0 || both) begin
      bad++;
      $display("FAIL open_exit got=%0d both=%b exp=0/0", bus.state, both);
    end
  endtask

  task automatic wait_alarm(input int exp_n);
    int n = 0;
    while (bus.alarm === 1'b1 && n < 200) begin
      n++;
      bus.key_valid = (n == 3);
      bus.key_value = 4'd1;
      bus.key_enter = (n == 5);
      bus.key_clear = (n == 7);
      step();
      bus.key_valid = 1'b0;
      bus.key_enter = 1'b0;
      bus.key_clear = 1'b0;
      if (bus.unlock === 1'b1) n = 1000;
    end
    m_err = 0;
    total++;
    if (n != exp_n) begin
      bad++;
      $display("FAIL alarm_len got=%0d exp=%0d", n, exp_n);
    end
    total++;
    if (bus.state !== 3'd0 || bus.err_cnt !== 2'd0) begin
      bad++;
      $display("FAIL alarm_exit got=%0d/%0d exp=0/0", bus.state, bus.err_cnt);
    end
    total++;
    if (bus.pw_entry !== 16'h0) begin
      bad++;
      $display("FAIL alarm_keys got=%h exp=0", bus.pw_entry);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    total++;
    if (bus.state !== 3'd0 || bus.pw_entry !== 16'h0
        || bus.digit_sel !== 2'd0 || bus.err_cnt !== 2'd0
        || bus.unlock !== 1'b0 || bus.alarm !== 1'b0) begin
      bad++;
      $display("FAIL %s got st=%0d pw=%h ds=%0d err=%0d u=%b a=%b exp all 0",
               tag, bus.state, bus.pw_entry, bus.digit_sel,
               bus.err_cnt, bus.unlock, bus.alarm);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2 chk_reset_vals("reset_vals");
    step();
    bus.key_valid = 1'b1;
    bus.key_value = 4'd1;
    @(negedge clk);
    reset = 1'b1;
    step();
    bus.key_valid = 1'b0;
    m_entry = 16'h0001;
    m_cnt = 1;
    total++;
    if (bus.pw_entry !== m_entry || bus.state !== 3'd1) begin
      bad++;
      $display("FAIL first_edge got=%h/%0d exp=0001/1", bus.pw_entry, bus.state);
    end
    bus.key_clear = 1'b1;
    step();
    bus.key_clear = 1'b0;
    m_entry = '0;
    m_cnt = 0;
    chk_reset_vals("clear_entry");
  endtask

  task automatic test_open();
    enter_code(16'h1234);
    submit();
    wait_open(32);
  endtask

  task automatic test_alarm();
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1235);
      submit();
    end
    wait_alarm(16);
  endtask

  task automatic test_short();
    press_digit(4'd1);
    press_digit(4'd2);
    submit();
  endtask

  task automatic test_limits();
    press_digit(4'd1);
    total++;
    if (bus.state !== 3'd1) begin
      bad++;
      $display("FAIL first_digit_state got=%0d exp=1", bus.state);
    end
    press_digit(4'hA);
    press_digit(4'd2);
    press_digit(4'd3);
    press_digit(4'd4);
    press_digit(4'd5);
    bus.key_clear = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_value = 4'd7;
    step();
    bus.key_clear = 1'b0;
    bus.key_valid = 1'b0;
    m_entry = '0;
    m_cnt = 0;
    total++;
    if (bus.pw_entry !== 16'h0 || bus.state !== 3'd0
        || bus.digit_sel !== 2'd0) begin
      bad++;
      $display("FAIL clear_prio got=%h/%0d/%0d exp=0/0/0",
               bus.pw_entry, bus.state, bus.digit_sel);
    end
  endtask

  task automatic test_setpw();
    enter_code(m_pw);
    submit();
    step();
    step();
    bus.set_mode = 1'b1;
    bus.key_enter = 1'b1;
    step();
    bus.key_enter = 1'b0;
    total++;
    if (bus.state !== 3'd4 || bus.unlock !== 1'b0) begin
      bad++;
      $display("FAIL setpw_entry got=%0d/%b exp=4/0", bus.state, bus.unlock);
    end
    enter_code(16'h9876);
    bus.key_enter = 1'b1;
    step();
    bus.key_enter = 1'b0;
    bus.set_mode = 1'b0;
    if (m_cnt == 4) m_pw = m_entry;
    m_entry = '0;
    m_cnt = 0;
    total++;
    if (bus.state !== 3'd0 || bus.pw_entry !== 16'h0) begin
      bad++;
      $display("FAIL setpw_exit got=%0d/%h exp=0/0", bus.state, bus.pw_entry);
    end
    enter_code(16'h1234);
    submit();
    enter_code(16'h9876);
    submit();
    wait_open(32);
  endtask

  task automatic test_reset_mid();
    enter_code(m_pw);
    submit();
    repeat (5) step();
    reset = 1'b0;
    #1 chk_reset_vals("reset_open");
    #2 reset = 1'b1;
    m_pw = 16'h1234;
    m_err = 0;
    m_entry = '0;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1111);
      submit();
    end
    repeat (4) step();
    reset = 1'b0;
    #1 chk_reset_vals("reset_alarm");
    #2 reset = 1'b1;
    m_err = 0;
    enter_code(16'h9876);
    submit();
    enter_code(16'h1234);
    submit();
    wait_open(32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_value = 4'd0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.set_mode = 1'b0;
    test_reset();
    test_open();
    test_alarm();
    test_short();
    test_limits();
    test_setpw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
